// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the two-port SDRAM arbiter.
// Owner ids: 0 is the video reader, 1 is the camera writer/CPU.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_S0 = 1'b0;
  localparam owner_t OWNER_S1 = 1'b1;

  localparam int DEF_ADDR_W   = 25;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_HOLD_MAX = 16;
  localparam int DEF_MAX_PEND = 8;

endpackage

// File: rtl/sdram_arb_owner_fifo.sv
// Records which requester issued each outstanding read, so returned data can be routed in order.
// A push into a full FIFO is allowed only in a cycle that also pops.
module sdram_arb_owner_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PEND
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  owner_t din,
  output logic   full,
  output logic   empty,
  output owner_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  owner_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester Avalon-style arbiter in front of one SDRAM controller, with bounded
// grant hold under contention and in-order read data routing.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output arb_state_t          state,
  output logic                err
);

  // Handshake: a request is taken when (m_read | m_write) is high and m_waitrequest is low;
  // a requester holds its command stable while its waitrequest is high.

  localparam int HW = $clog2(HOLD_MAX + 1);

  arb_state_t    state_next;
  logic [HW-1:0] hold_cnt;
  logic          req0, req1;
  logic          accept, stall, hold_hit;
  logic          fifo_full, fifo_empty;
  owner_t        fifo_head;
  logic          read_block;

  assign req0       = s0_read || s0_write;
  assign req1       = s1_read || s1_write;
  // A return in the same cycle frees a slot, so a read may be taken alongside the pop.
  assign read_block = fifo_full && !m_readdatavalid;

  always_comb begin
    m_address      = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    m_writedata    = '0;
    m_byteenable   = '0;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    unique case (state)
      ST_GNT0: begin
        m_address      = s0_address;
        m_read         = s0_read && !read_block;
        m_write        = s0_write;
        m_writedata    = s0_writedata;
        m_byteenable   = s0_byteenable;
        s0_waitrequest = m_waitrequest || (s0_read && read_block);
      end
      ST_GNT1: begin
        m_address      = s1_address;
        m_read         = s1_read && !read_block;
        m_write        = s1_write;
        m_writedata    = s1_writedata;
        m_byteenable   = s1_byteenable;
        s1_waitrequest = m_waitrequest || (s1_read && read_block);
      end
      default: ;
    endcase
  end

  assign accept   = (m_read || m_write) && !m_waitrequest;
  assign stall    = (m_read || m_write) && m_waitrequest;
  assign hold_hit = accept && (hold_cnt >= HW'(HOLD_MAX - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (req0)      state_next = ST_GNT0;
        else if (req1) state_next = ST_GNT1;
      end
      ST_GNT0: begin
        if (!stall) begin
          if (!req0)                 state_next = req1 ? ST_GNT1 : ST_IDLE;
          else if (hold_hit && req1) state_next = ST_GNT1;
        end
      end
      ST_GNT1: begin
        if (!stall) begin
          if (!req1)                 state_next = req0 ? ST_GNT0 : ST_IDLE;
          else if (hold_hit && req0) state_next = ST_GNT0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)                        hold_cnt <= '0;
      else if (accept && hold_cnt != HW'(HOLD_MAX))   hold_cnt <= hold_cnt + HW'(1);
      if (m_readdatavalid && fifo_empty) err <= 1'b1;
    end
  end

  sdram_arb_owner_fifo #(.DEPTH(MAX_PEND)) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && m_read),
    .pop   (m_readdatavalid),
    .din   ((state == ST_GNT1) ? OWNER_S1 : OWNER_S0),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = m_readdatavalid && !fifo_empty && (fifo_head == OWNER_S0);
  assign s1_readdatavalid = m_readdatavalid && !fifo_empty && (fifo_head == OWNER_S1);

endmodule
